// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared funct3 encodings and LSU state type
package riscv_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam int TIMER_W = 10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2,
        DONE = 2'd3
    } lsu_state_t;

endpackage

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - store lane/byte-enable formation, load extract/extend, misalign detect
module lsu_align
    import riscv_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] store_data,
    input  logic [31:0] load_word,
    output logic [31:0] lane_wdata,
    output logic [3:0]  lane_be,
    output logic [31:0] load_ext,
    output logic        misaligned
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        byte_v     = 8'(load_word >> {addr_lo, 3'b000});
        half_v     = 16'(load_word >> {addr_lo[1], 4'b0000});
        lane_wdata = store_data;
        lane_be    = 4'b1111;
        load_ext   = load_word;
        misaligned = 1'b0;
        case (funct3)
            F3_B, F3_BU: begin
                lane_wdata = {4{store_data[7:0]}};
                lane_be    = 4'b0001 << addr_lo;
                load_ext   = (funct3 == F3_B) ? {{24{byte_v[7]}}, byte_v}
                                              : {24'h0, byte_v};
            end
            F3_H, F3_HU: begin
                lane_wdata = {2{store_data[15:0]}};
                lane_be    = addr_lo[1] ? 4'b1100 : 4'b0011;
                load_ext   = (funct3 == F3_H) ? {{16{half_v[15]}}, half_v}
                                              : {16'h0, half_v};
                misaligned = addr_lo[0];
            end
            // 010, 011, 110 and 111 all behave as full-word accesses
            default: begin
                misaligned = |addr_lo;
            end
        endcase
    end

endmodule

// File: rtl/mem_stage_lsu.sv
// rtl/mem_stage_lsu.sv - M-stage load/store unit with req/gnt/rvalid data memory handshake
module mem_stage_lsu
    import riscv_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MemRead_M,
    input  logic        MemWrite_M,
    input  logic [2:0]  funct3_M,
    input  logic [31:0] ALUResult_M,
    input  logic [31:0] WriteData_M,
    output logic [31:0] ReadData_M,
    output logic        Stall_M,
    output logic        Misaligned_M,
    output logic        BusErr_M,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic        dmem_gnt,
    input  logic        dmem_rvalid,
    input  logic [31:0] dmem_rdata
);

    lsu_state_t         state;
    logic [TIMER_W-1:0] timer;
    logic [31:0]        rbuf;
    logic               buserr_q;

    logic        op;
    logic        misaligned;
    logic        start;
    logic        timeout_hit;
    logic [31:0] lane_wdata;
    logic [3:0]  lane_be;
    logic [31:0] load_ext;

    lsu_align u_align (
        .funct3     (funct3_M),
        .addr_lo    (ALUResult_M[1:0]),
        .store_data (WriteData_M),
        .load_word  (rbuf),
        .lane_wdata (lane_wdata),
        .lane_be    (lane_be),
        .load_ext   (load_ext),
        .misaligned (misaligned)
    );

    assign op          = MemRead_M | MemWrite_M;
    assign start       = op & ~misaligned;
    assign timeout_hit = (timer == TIMER_W'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            timer      <= '0;
            rbuf       <= '0;
            buserr_q   <= 1'b0;
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            dmem_wdata <= '0;
            dmem_be    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state      <= REQ;
                        timer      <= '0;
                        rbuf       <= '0;
                        buserr_q   <= 1'b0;
                        dmem_req   <= 1'b1;
                        dmem_we    <= MemWrite_M;
                        dmem_addr  <= {ALUResult_M[31:2], 2'b00};
                        dmem_wdata <= MemWrite_M ? lane_wdata : 32'h0;
                        dmem_be    <= MemWrite_M ? lane_be : 4'b0000;
                    end
                end
                REQ: begin
                    // a grant arriving on the last allowed cycle still wins
                    if (dmem_gnt) begin
                        dmem_req <= 1'b0;
                        timer    <= '0;
                        state    <= dmem_we ? DONE : RESP;
                    end else if (timeout_hit) begin
                        dmem_req <= 1'b0;
                        buserr_q <= 1'b1;
                        state    <= DONE;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                RESP: begin
                    if (dmem_rvalid) begin
                        rbuf  <= dmem_rdata;
                        state <= DONE;
                    end else if (timeout_hit) begin
                        buserr_q <= 1'b1;
                        state    <= DONE;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Stall is gated by rst so a reset mid-access releases the pipeline immediately
    assign Stall_M      = ~rst & (((state == IDLE) & start) | (state == REQ) | (state == RESP));
    assign Misaligned_M = (state == IDLE) & op & misaligned;
    assign BusErr_M     = (state == DONE) & buserr_q;
    assign ReadData_M   = ((state == DONE) & ~dmem_we & ~buserr_q) ? load_ext : 32'h0;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// tb/tb_mem_stage_lsu.sv - scoreboard bench for mem_stage_lsu
module tb_mem_stage_lsu;

    logic        clk = 1'b0;
    logic        rst;
    logic        MemRead_M, MemWrite_M;
    logic [2:0]  funct3_M;
    logic [31:0] ALUResult_M, WriteData_M;
    logic [31:0] ReadData_M;
    logic        Stall_M, Misaligned_M, BusErr_M;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_gnt, dmem_rvalid;
    logic [31:0] dmem_rdata;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] rd;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [3:0]  be;
        logic        we;
        logic        mis;
        logic        berr;
        int          stalls;
    } exp_t;

    exp_t sb[$];

    mem_stage_lsu #(.TIMEOUT(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .MemRead_M    (MemRead_M),
        .MemWrite_M   (MemWrite_M),
        .funct3_M     (funct3_M),
        .ALUResult_M  (ALUResult_M),
        .WriteData_M  (WriteData_M),
        .ReadData_M   (ReadData_M),
        .Stall_M      (Stall_M),
        .Misaligned_M (Misaligned_M),
        .BusErr_M     (BusErr_M),
        .dmem_req     (dmem_req),
        .dmem_we      (dmem_we),
        .dmem_addr    (dmem_addr),
        .dmem_wdata   (dmem_wdata),
        .dmem_be      (dmem_be),
        .dmem_gnt     (dmem_gnt),
        .dmem_rvalid  (dmem_rvalid),
        .dmem_rdata   (dmem_rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                                   input logic [31:0] wdata, input logic [31:0] rdata,
                                   input int gnt_wait, input int rv_wait);
        exp_t e;
        int   sz;
        logic [7:0]  b;
        logic [15:0] h;
        sz = (f3 == 3'b000 || f3 == 3'b100) ? 1 : (f3 == 3'b001 || f3 == 3'b101) ? 2 : 4;
        case (addr[1:0])
            2'd0: b = rdata[7:0];
            2'd1: b = rdata[15:8];
            2'd2: b = rdata[23:16];
            default: b = rdata[31:24];
        endcase
        h = addr[1] ? rdata[31:16] : rdata[15:0];
        e.addr = addr & 32'hFFFF_FFFC;
        e.we   = wr;
        e.mis  = (sz == 2 && addr[0]) || (sz == 4 && addr[1:0] != 2'b00);
        e.berr = (gnt_wait < 0);
        e.be   = 4'b0000;
        e.wd   = 32'h0;
        if (wr) begin
            if (sz == 1) begin
                e.wd = {wdata[7:0], wdata[7:0], wdata[7:0], wdata[7:0]};
                case (addr[1:0])
                    2'd0: e.be = 4'b0001;
                    2'd1: e.be = 4'b0010;
                    2'd2: e.be = 4'b0100;
                    default: e.be = 4'b1000;
                endcase
            end else if (sz == 2) begin
                e.wd = {wdata[15:0], wdata[15:0]};
                e.be = addr[1] ? 4'b1100 : 4'b0011;
            end else begin
                e.wd = wdata;
                e.be = 4'b1111;
            end
        end
        e.rd = 32'h0;
        if (!wr && !e.mis && !e.berr) begin
            case (f3)
                3'b000: e.rd = {{24{b[7]}}, b};
                3'b100: e.rd = {24'h0, b};
                3'b001: e.rd = {{16{h[15]}}, h};
                3'b101: e.rd = {16'h0, h};
                default: e.rd = rdata;
            endcase
        end
        if (e.mis)       e.stalls = 0;
        else if (e.berr) e.stalls = 1 + 4;
        else             e.stalls = 1 + (gnt_wait + 1) + (wr ? 0 : rv_wait + 1);
        return e;
    endfunction

    // gnt_wait < 0 means the memory never grants
    task automatic access(input logic rd, input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] rdata,
                          input int gnt_wait, input int rv_wait);
        exp_t x;
        int   req_n, resp_n, stalls;
        bit   granted, saw_req, done, req_checked;
        sb.push_back(model(wr, f3, addr, wdata, rdata, gnt_wait, rv_wait));
        req_n = 0; resp_n = 0; stalls = 0;
        granted = 0; saw_req = 0; done = 0; req_checked = 0;
        @(posedge clk); #1;
        MemRead_M = rd; MemWrite_M = wr; funct3_M = f3; ALUResult_M = addr; WriteData_M = wdata;
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge clk);
            dmem_gnt = 1'b0;
            dmem_rvalid = 1'b0;
            if (!Stall_M) begin
                done = 1;
                x = sb.pop_front();
                check("rdata", ReadData_M, x.rd);
                check("buserr", {31'h0, BusErr_M}, {31'h0, x.berr});
                check("misaligned", {31'h0, Misaligned_M}, {31'h0, x.mis});
                check("stall_cycles", stalls, x.stalls);
                check("req_low_at_end", {31'h0, dmem_req}, 32'h0);
                check("req_seen", {31'h0, saw_req}, {31'h0, ~x.mis});
                if (saw_req) begin
                    check("addr", dmem_addr, x.addr);
                    check("we", {31'h0, dmem_we}, {31'h0, x.we});
                    check("be", {28'h0, dmem_be}, {28'h0, x.be});
                    check("wdata", dmem_wdata, x.wd);
                end
            end else begin
                stalls++;
                if (dmem_req) begin
                    saw_req = 1;
                    if (!req_checked) begin
                        req_checked = 1;
                        check("req_addr", dmem_addr, sb[0].addr);
                        check("req_be", {28'h0, dmem_be}, {28'h0, sb[0].be});
                    end
                    if (gnt_wait >= 0 && req_n == gnt_wait) begin
                        dmem_gnt = 1'b1;
                        granted = 1;
                    end
                    req_n++;
                end else if (granted) begin
                    if (resp_n == rv_wait) begin
                        dmem_rvalid = 1'b1;
                        dmem_rdata = rdata;
                    end
                    resp_n++;
                end
            end
        end
        if (!done) begin
            check("access_completes", 32'h0, 32'h1);
            void'(sb.pop_front());
        end
        @(posedge clk); #1;
        MemRead_M = 1'b0; MemWrite_M = 1'b0;
        dmem_rdata = 32'h0;
    endtask

    initial begin
        rst = 1'b1;
        MemRead_M = 0; MemWrite_M = 0; funct3_M = 3'b000;
        ALUResult_M = 0; WriteData_M = 0;
        dmem_gnt = 0; dmem_rvalid = 0; dmem_rdata = 0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_rdata", ReadData_M, 32'h0);
        check("rst_stall", {31'h0, Stall_M}, 32'h0);
        check("rst_req", {31'h0, dmem_req}, 32'h0);
        check("rst_be", {28'h0, dmem_be}, 32'h0);
        check("rst_addr", dmem_addr, 32'h0);
        check("rst_buserr", {31'h0, BusErr_M}, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        access(0, 1, 3'b010, 32'h100, 32'hDEADBEEF, 32'h0, 0, 0);          // SW
        access(1, 0, 3'b000, 32'h103, 32'h0, 32'h80FF_0000, 0, 0);         // LB
        access(1, 0, 3'b100, 32'h103, 32'h0, 32'h80FF_0000, 0, 0);         // LBU
        access(1, 0, 3'b001, 32'h102, 32'h0, 32'h8001_1234, 0, 0);         // LH
        access(0, 1, 3'b001, 32'h102, 32'h0000_ABCD, 32'h0, 0, 0);         // SH
        access(1, 0, 3'b010, 32'h101, 32'h0, 32'h1234_5678, 0, 0);         // LW misaligned
        access(1, 0, 3'b010, 32'h104, 32'h0, 32'h0, -1, 0);                // LW timeout
        access(1, 0, 3'b101, 32'h200, 32'h0, 32'h1234_F00D, 2, 1);         // LHU delayed
        access(0, 1, 3'b000, 32'h301, 32'h0000_005A, 32'h0, 1, 0);         // SB lane 1
        access(1, 0, 3'b000, 32'h300, 32'h0, 32'hAAAA_AA7F, 0, 2);         // LB positive
        access(0, 1, 3'b001, 32'h305, 32'h0000_1111, 32'h0, 0, 0);         // SH misaligned

        // reset while waiting in RESP
        @(posedge clk); #1;
        MemRead_M = 1; funct3_M = 3'b010; ALUResult_M = 32'h200;
        @(negedge clk);
        @(negedge clk);
        check("rst_test_req", {31'h0, dmem_req}, 32'h1);
        dmem_gnt = 1'b1;
        @(negedge clk);
        dmem_gnt = 1'b0;
        check("rst_test_resp_stall", {31'h0, Stall_M}, 32'h1);
        check("rst_test_resp_req", {31'h0, dmem_req}, 32'h0);
        #2 rst = 1'b1;
        #1;
        check("midrst_req", {31'h0, dmem_req}, 32'h0);
        check("midrst_stall", {31'h0, Stall_M}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        MemRead_M = 1'b0;
        dmem_rvalid = 1'b1;
        dmem_rdata = 32'hFFFF_FFFF;
        @(negedge clk);
        dmem_rvalid = 1'b0;
        check("late_rvalid_stall", {31'h0, Stall_M}, 32'h0);
        check("late_rvalid_rdata", ReadData_M, 32'h0);
        check("late_rvalid_req", {31'h0, dmem_req}, 32'h0);

        access(1, 0, 3'b010, 32'h208, 32'h0, 32'hCAFE_BABE, 0, 0);         // LW after reset

        check("scoreboard_empty", sb.size(), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
